muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  RV32M multiply/divide execute unit; sits directly downstream of the register file.
//  Consumes rs1/rs2 read data plus rd address; produces rd write data for the register-file write port.
//  Multi-cycle iterative datapath with valid/ready handshake on issue and writeback sides.
// PARAMETERS
//  XLEN        32  operand/result width (only 32 supported)
//  ADDR_W      5   register address width
// PORTS
//  iClk        in   1      clock; all state changes on posedge
//  iRst        in   1      reset, synchronous, active-high
//  iValid      in   1      issue request valid
//  oReady      out  1      unit idle, can accept (high only in IDLE)
//  iFunct3     in   3      000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  iRs1Data    in   XLEN   dividend / multiplicand (register-file rs1 read data)
//  iRs2Data    in   XLEN   divisor / multiplier (register-file rs2 read data)
//  iRdAddr     in   ADDR_W destination register
//  iKill       in   1      abort in-flight op (pipeline flush)
//  oValid      out  1      result valid (drives register-file write enable)
//  iWbReady    in   1      writeback port free this cycle
//  oRdAddr     out  ADDR_W destination register of result
//  oWriteData  out  XLEN   result
// BEHAVIOUR
//  Reset: iRst high at posedge -> state IDLE, oReady=1, oValid=0, oRdAddr=0, oWriteData=0, counter=0.
//  FSM: IDLE -> BUSY -> FIX -> DONE -> IDLE.
//   IDLE: accept on iValid&&oReady; latch funct3, operands, rd; go BUSY, cnt=0.
//   BUSY: one bit per cycle (shift-add mul / restoring div on magnitudes); cnt 0..31; at cnt==31 -> FIX.
//   FIX: apply sign correction, select hi/lo or quotient/remainder -> DONE.
//   DONE: oValid=1; oRdAddr/oWriteData held stable until iValid... no: until iWbReady; on oValid&&iWbReady -> IDLE.
//  Latency (counting accepting edge as edge 1): iterative ops oValid high after edge 34; fast-path ops after edge 2.
//  Fast path (accept -> FIX directly, skipping BUSY):
//   div by zero: DIV/DIVU q=0xFFFFFFFF; REM/REMU r=rs1.
//   signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV q=0x80000000; REM r=0.
//  Arithmetic: MUL low 32 of product; MULH signed x signed high 32; MULHSU signed rs1 x unsigned rs2 high 32;
//   MULHU unsigned high 32. DIV/REM truncate toward zero; remainder takes dividend sign.
//  Internal product 64 bits; magnitudes computed 32-bit unsigned; negation of 0x80000000 kept as unsigned 2^31.
//  rd==x0: op executes and handshakes normally; register file discards the write.
//  iKill: any state -> IDLE at next edge, oValid=0 next cycle; kill beats a same-cycle accept (no accept).
//  Kill in DONE with iWbReady same cycle: write is dropped (oValid qualified by !iKill combinationally).
//  Backpressure: DONE with iWbReady=0 holds indefinitely; outputs must not change.
//  oReady deasserts the cycle after accept; no second request accepted until return to IDLE.
//  iRst mid-op: immediate return to reset state; no partial result emitted.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use single combinational 33x33 signed multiply,
//   accept -> FIX -> DONE (oValid after edge 2); divide path unchanged.
//  Not defined: all multiplies iterative, 34-edge latency; no hard multiplier inferred.
// STRUCTURE
//  muldiv_pkg: funct3 encodings (F3_MUL..F3_REMU), state encoding (S_IDLE,S_BUSY,S_FIX,S_DONE),
//   constants DIV0_QUOT=32'hFFFFFFFF, INT_MIN=32'h80000000, ITER_LAST=5'd31.
//  Sub-module muldiv_iter_core: per-cycle shift-add/restoring-subtract step (acc, operand regs, step enable);
//   muldiv_unit owns FSM, handshake, sign fix and fast paths.
// TESTING
//  1 MUL rs1=7 rs2=0xFFFFFFFD, rd=5, iWbReady=1 -> oWriteData=0xFFFFFFEB, oRdAddr=5, oValid after edge 34 (2 w/ FAST_MUL).
//  2 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0x00000000; MULHSU same -> 0xFFFFFFFF.
//  3 DIV 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; both oValid after edge 2.
//  4 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
//  5 DIV 20/3 with iWbReady=0 for 10 cycles in DONE -> oValid, oWriteData=6 stable throughout; oReady=0 until handshake.
//  6 iKill at BUSY cnt=10 -> IDLE next edge, no oValid; iRst mid-op -> all outputs reset values, oReady=1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    // funct3 encodings of the RV32M instructions
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [4:0]  ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_t;

    // Magnitude of an optionally signed operand; -INT_MIN stays 0x80000000 read as unsigned 2^31.
    function automatic logic [31:0] abs_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on unsigned magnitudes.
// Multiply: o_hi:o_lo = i_op * i_init_lo. Divide: o_lo = i_init_lo / i_op, o_hi = remainder.
module muldiv_iter_core (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_is_div,
    input  logic [31:0] i_op,
    input  logic [31:0] i_init_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_op;

    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;

    // Per-step arithmetic for both iteration flavours
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : 33'd0);
        w_shift = {r_hi, r_lo[31]};
        w_ge    = (w_shift >= {1'b0, r_op});
        // True difference is below the divisor when w_ge holds, so the 32-bit wrap is exact
        w_sub   = w_shift[31:0] - r_op;
    end

    // Operand load on issue, one iteration per enabled cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi <= '0;
            r_lo <= '0;
            r_op <= '0;
        end else if (i_load) begin
            r_hi <= '0;
            r_lo <= i_init_lo;
            r_op <= i_op;
        end else if (i_step) begin
            if (i_is_div) begin
                r_hi <= w_ge ? w_sub : w_shift[31:0];
                r_lo <= {r_lo[30:0], w_ge};
            end else begin
                r_hi <= w_sum[32:1];
                r_lo <= {w_sum[0], r_lo[31:1]};
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit with issue and writeback valid/ready handshakes.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single combinational multiplier and skip BUSY.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic [2:0]        iFunct3,
    input  logic [XLEN-1:0]   iRs1Data,
    input  logic [XLEN-1:0]   iRs2Data,
    input  logic [ADDR_W-1:0] iRdAddr,
    input  logic              iKill,
    output logic              oValid,
    input  logic              iWbReady,
    output logic [ADDR_W-1:0] oRdAddr,
    output logic [XLEN-1:0]   oWriteData
);

    state_t              r_state;
    state_t              w_state_next;
    logic [4:0]          r_cnt;
    logic [2:0]          r_f3;
    logic [ADDR_W-1:0]   r_rd;
    logic                r_neg_main;
    logic                r_neg_rem;
    logic                r_use_fast;
    logic [31:0]         r_fast_val;
    logic [31:0]         r_wdata;

    logic        w_accept;
    logic        w_is_div;
    logic        w_sgn_a;
    logic        w_sgn_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div0;
    logic        w_ovf;
    logic        w_fast;
    logic [31:0] w_fast_val;
    logic        w_fast_mul;
    logic [31:0] w_fast_mul_val;
    logic [31:0] w_core_hi;
    logic [31:0] w_core_lo;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_result;

    // Issue-side decode: operand signedness, magnitudes and special cases
    always_comb begin
        w_accept = (r_state == S_IDLE) && iValid && !iKill;
        w_is_div = iFunct3[2];
        w_sgn_a  = (iFunct3 == F3_MULH) || (iFunct3 == F3_MULHSU) ||
                   (iFunct3 == F3_DIV)  || (iFunct3 == F3_REM);
        w_sgn_b  = (iFunct3 == F3_MULH) || (iFunct3 == F3_DIV) || (iFunct3 == F3_REM);
        w_mag_a  = abs_mag(iRs1Data, w_sgn_a);
        w_mag_b  = abs_mag(iRs2Data, w_sgn_b);
        w_div0   = w_is_div && (iRs2Data == 32'd0);
        w_ovf    = ((iFunct3 == F3_DIV) || (iFunct3 == F3_REM)) &&
                   (iRs1Data == INT_MIN) && (iRs2Data == 32'hFFFF_FFFF);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fm_a;
    logic [63:0] w_fm_b;
    logic [63:0] w_fm_p;
    // 33-bit signed operands sign-extended; the low 64 product bits are exact
    always_comb begin
        w_fm_a         = {{32{w_sgn_a & iRs1Data[31]}}, iRs1Data};
        w_fm_b         = {{32{w_sgn_b & iRs2Data[31]}}, iRs2Data};
        w_fm_p         = w_fm_a * w_fm_b;
        w_fast_mul     = !w_is_div;
        w_fast_mul_val = (iFunct3 == F3_MUL) ? w_fm_p[31:0] : w_fm_p[63:32];
    end
`else
    assign w_fast_mul     = 1'b0;
    assign w_fast_mul_val = 32'd0;
`endif

    // Results that bypass the iterative datapath
    always_comb begin
        w_fast = w_div0 || w_ovf || w_fast_mul;
        if (w_fast_mul) begin
            w_fast_val = w_fast_mul_val;
        end else if (w_div0) begin
            w_fast_val = iFunct3[1] ? iRs1Data : DIV0_QUOT;
        end else begin
            w_fast_val = iFunct3[1] ? 32'd0 : INT_MIN;
        end
    end

    muldiv_iter_core u_core (
        .i_clk     (iClk),
        .i_rst     (iRst),
        .i_load    (w_accept),
        .i_step    (r_state == S_BUSY),
        .i_is_div  (w_is_div ? 1'b1 : 1'b0),
        .i_op      (w_is_div ? w_mag_b : w_mag_a),
        .i_init_lo (w_is_div ? w_mag_a : w_mag_b),
        .o_hi      (w_core_hi),
        .o_lo      (w_core_lo)
    );

    // Sign correction and result selection, consumed in FIX
    always_comb begin
        w_prod = {w_core_hi, w_core_lo};
        if (r_neg_main) begin
            w_prod = 64'd0 - w_prod;
        end
        w_quot = r_neg_main ? (32'd0 - w_core_lo) : w_core_lo;
        w_rem  = r_neg_rem  ? (32'd0 - w_core_hi) : w_core_hi;
        if (r_use_fast) begin
            w_result = r_fast_val;
        end else if (r_f3[2]) begin
            w_result = r_f3[1] ? w_rem : w_quot;
        end else begin
            w_result = (r_f3 == F3_MUL) ? w_prod[31:0] : w_prod[63:32];
        end
    end

    // Next-state logic and handshake outputs; kill overrides everything
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (iValid) w_state_next = w_fast ? S_FIX : S_BUSY;
            S_BUSY: if (r_cnt == ITER_LAST) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_DONE;
            S_DONE: if (iWbReady) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (iKill) begin
            w_state_next = S_IDLE;
        end
        oReady = (r_state == S_IDLE);
        oValid = (r_state == S_DONE) && !iKill;
    end

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Issue latch, iteration counter and result register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_cnt      <= '0;
            r_f3       <= '0;
            r_rd       <= '0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_use_fast <= 1'b0;
            r_fast_val <= '0;
            r_wdata    <= '0;
        end else begin
            if (w_accept) begin
                r_cnt      <= '0;
                r_f3       <= iFunct3;
                r_rd       <= iRdAddr;
                r_neg_main <= (w_sgn_a & iRs1Data[31]) ^ (w_sgn_b & iRs2Data[31]);
                r_neg_rem  <= w_sgn_a & iRs1Data[31];
                r_use_fast <= w_fast;
                r_fast_val <= w_fast_val;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 5'd1;
            end
            if ((r_state == S_FIX) && !iKill) begin
                r_wdata <= w_result;
            end
        end
    end

    assign oRdAddr    = r_rd;
    assign oWriteData = r_wdata;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iValid = 1'b0;
    logic        oReady;
    logic [2:0]  iFunct3 = '0;
    logic [31:0] iRs1Data = '0;
    logic [31:0] iRs2Data = '0;
    logic [4:0]  iRdAddr = '0;
    logic        iKill = 1'b0;
    logic        oValid;
    logic        iWbReady = 1'b1;
    logic [4:0]  oRdAddr;
    logic [31:0] oWriteData;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 iClk = ~iClk;

    muldiv_unit #(.XLEN(32), .ADDR_W(5)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iValid     (iValid),
        .oReady     (oReady),
        .iFunct3    (iFunct3),
        .iRs1Data   (iRs1Data),
        .iRs2Data   (iRs2Data),
        .iRdAddr    (iRdAddr),
        .iKill      (iKill),
        .oValid     (oValid),
        .iWbReady   (iWbReady),
        .oRdAddr    (oRdAddr),
        .oWriteData (oWriteData)
    );

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        logic [63:0] sa;
        logic [63:0] sb64;
        sa   = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb64;               return p[63:32]; end
            3'd2: begin p = sa * {32'd0, b};         return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2]) begin
            if (b == 0) return 2;
            if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
            return 34;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 2;
`else
        return 34;
`endif
    endfunction

    // Issue one op, wait for its result, optionally stall writeback, then retire it
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int stall);
        exp_t e;
        int   n;
        @(negedge iClk);
        iValid = 1'b1; iFunct3 = f3; iRs1Data = a; iRs2Data = b; iRdAddr = rd;
        iWbReady = (stall == 0);
        sb.push_back('{rd: rd, data: model(f3, a, b), lat: exp_lat(f3, a, b)});
        @(posedge iClk); #1;
        iValid = 1'b0;
        n = 1;
        n_checks++;
        if (oReady !== 1'b0) begin
            n_errors++; $display("FAIL ready_after_accept: got %b want 0", oReady);
        end
        while (oValid !== 1'b1 && n < 100) begin
            @(posedge iClk); #1; n++;
        end
        e = sb.pop_front();
        n_checks++;
        if (n !== e.lat) begin
            n_errors++; $display("FAIL latency f3=%0d: got %0d edges want %0d", f3, n, e.lat);
        end
        n_checks++;
        if (oValid !== 1'b1 || oWriteData !== e.data) begin
            n_errors++;
            $display("FAIL data f3=%0d a=%h b=%h: got v=%b %h want %h", f3, a, b, oValid,
                     oWriteData, e.data);
        end
        n_checks++;
        if (oRdAddr !== e.rd) begin
            n_errors++; $display("FAIL rd: got %0d want %0d", oRdAddr, e.rd);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge iClk); #1;
            n_checks++;
            if (oValid !== 1'b1 || oWriteData !== e.data || oRdAddr !== e.rd ||
                oReady !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold cyc=%0d: got v=%b d=%h rd=%0d rdy=%b want 1 %h %0d 0",
                         i, oValid, oWriteData, oRdAddr, oReady, e.data, e.rd);
            end
        end
        if (stall > 0) begin
            @(negedge iClk); iWbReady = 1'b1;
        end
        @(posedge iClk); #1;
        n_checks++;
        if (oValid !== 1'b0 || oReady !== 1'b1) begin
            n_errors++;
            $display("FAIL handshake_retire: got v=%b rdy=%b want 0 1", oValid, oReady);
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        n_checks++;
        if (oReady !== 1'b1 || oValid !== 1'b0 || oRdAddr !== 5'd0 || oWriteData !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b v=%b rd=%0d d=%h want 1 0 0 0", oReady,
                     oValid, oRdAddr, oWriteData);
        end
        @(negedge iClk); iRst = 1'b0;
    endtask

    task automatic test_mul();
        do_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
        do_op(F3_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 0);
    endtask

    task automatic test_mul_high();
        do_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
        do_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
        do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
        do_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd4, 0);
    endtask

    task automatic test_div_fast();
        do_op(F3_DIV,  32'd100, 32'd0, 5'd6, 0);
        do_op(F3_REMU, 32'd100, 32'd0, 5'd7, 0);
        do_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
        do_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
    endtask

    task automatic test_div_signed();
        do_op(F3_REM,  32'hFFFF_FFF9, 32'd2, 5'd10, 0);
        do_op(F3_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd11, 0);
        do_op(F3_DIV,  32'hFFFF_FFF9, 32'd2, 5'd12, 0);
        do_op(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    endtask

    task automatic test_backpressure();
        do_op(F3_DIV, 32'd20, 32'd3, 5'd14, 10);
    endtask

    task automatic test_kill();
        int seen;
        @(negedge iClk);
        iValid = 1'b1; iFunct3 = F3_DIV; iRs1Data = 32'd1000; iRs2Data = 32'd7; iRdAddr = 5'd3;
        iWbReady = 1'b1;
        @(posedge iClk); #1;
        iValid = 1'b0;
        repeat (10) @(posedge iClk);
        @(negedge iClk); iKill = 1'b1;
        @(posedge iClk); #1;
        iKill = 1'b0;
        n_checks++;
        if (oReady !== 1'b1 || oValid !== 1'b0) begin
            n_errors++; $display("FAIL kill_busy: got rdy=%b v=%b want 1 0", oReady, oValid);
        end
        seen = 0;
        repeat (40) begin
            @(posedge iClk); #1;
            if (oValid !== 1'b0 || oReady !== 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++; $display("FAIL kill_no_result: got %0d bad cycles want 0", seen);
        end
        // Kill and issue in the same cycle: nothing is accepted
        @(negedge iClk); iValid = 1'b1; iKill = 1'b1;
        @(posedge iClk); #1;
        iValid = 1'b0; iKill = 1'b0;
        n_checks++;
        if (oReady !== 1'b1) begin
            n_errors++; $display("FAIL kill_beats_accept: got rdy=%b want 1", oReady);
        end
        // Kill in DONE while writeback is ready: write is dropped
        @(negedge iClk);
        iValid = 1'b1; iFunct3 = F3_DIVU; iRs1Data = 32'd5; iRs2Data = 32'd0; iWbReady = 1'b0;
        @(posedge iClk); #1;
        iValid = 1'b0;
        @(posedge iClk); #1;
        n_checks++;
        if (oValid !== 1'b1) begin
            n_errors++; $display("FAIL kill_done_setup: got v=%b want 1", oValid);
        end
        @(negedge iClk); iKill = 1'b1; iWbReady = 1'b1;
        #1;
        n_checks++;
        if (oValid !== 1'b0) begin
            n_errors++; $display("FAIL kill_done_gate: got v=%b want 0", oValid);
        end
        @(posedge iClk); #1;
        iKill = 1'b0;
        n_checks++;
        if (oReady !== 1'b1 || oValid !== 1'b0) begin
            n_errors++; $display("FAIL kill_done_idle: got rdy=%b v=%b want 1 0", oReady, oValid);
        end
        do_op(F3_DIVU, 32'd1000, 32'd7, 5'd15, 0);
    endtask

    task automatic test_rst_midop();
        int seen;
        @(negedge iClk);
        iValid = 1'b1; iFunct3 = F3_DIVU; iRs1Data = 32'd999; iRs2Data = 32'd4; iRdAddr = 5'd21;
        iWbReady = 1'b1;
        @(posedge iClk); #1;
        iValid = 1'b0;
        repeat (5) @(posedge iClk);
        @(negedge iClk); iRst = 1'b1;
        @(posedge iClk); #1;
        n_checks++;
        if (oReady !== 1'b1 || oValid !== 1'b0 || oRdAddr !== 5'd0 || oWriteData !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_midop: got rdy=%b v=%b rd=%0d d=%h want 1 0 0 0", oReady, oValid,
                     oRdAddr, oWriteData);
        end
        @(negedge iClk); iRst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge iClk); #1;
            if (oValid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++; $display("FAIL rst_no_result: got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 10; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 1) b = 32'($urandom_range(0, 9));
            do_op(f3, a, b, 5'(i + 16), 0);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div_fast();
        test_div_signed();
        test_backpressure();
        test_kill();
        test_rst_midop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
